// File: rtl/sobol_u_gen.sv
`default_nettype none
// ============================================================================
//  Module   : sobol_u_gen
//  Purpose  : One-dimensional Sobol low-discrepancy sample generator that
//             emits uniform samples u in [0,1), Q(WIDTH-QFRAC).QFRAC format,
//             one per cycle under a valid/ready handshake.
//  Ports    : clk          - rising-edge clock
//             rst_n        - synchronous active-low reset
//             start        - single-cycle run request (accepted in IDLE only)
//             num_samples  - samples to emit, captured with start (clamped)
//             dir_we       - direction-table write enable (IDLE only)
//             dir_addr     - direction-table index k
//             dir_data     - direction number v_k
//             ready_in     - downstream accepts the current sample
//             valid_out    - u holds a valid sample (state RUN)
//             u            - sample, integer bits zero
//             busy         - high while in RUN
//             done         - one-cycle pulse at run completion
//  Revision : 1.0 - initial release
// ============================================================================
module sobol_u_gen #(
  parameter int WIDTH     = 32,
  parameter int QFRAC     = 16,
  parameter int SKIP_ZERO = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [31:0]                num_samples,
  input  logic                       dir_we,
  input  logic [$clog2(QFRAC)-1:0]   dir_addr,
  input  logic [QFRAC-1:0]           dir_data,
  input  logic                       ready_in,
  output logic                       valid_out,
  output logic signed [WIDTH-1:0]    u,
  output logic                       busy,
  output logic                       done
);

  localparam int AW = $clog2(QFRAC);
  localparam int CW = QFRAC + 1;

  // Largest run length: every index from SKIP_ZERO to 2^QFRAC-1 once.
  localparam logic [32:0] c_MAX_SAMPLES = (33'd1 << QFRAC) - 33'(SKIP_ZERO);
  localparam logic [QFRAC-1:0] c_N_START = (SKIP_ZERO != 0) ? QFRAC'(1) : '0;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [QFRAC-1:0] dir_q [QFRAC];
  logic [QFRAC-1:0] x_q, x_d;
  logic [QFRAC-1:0] n_q, n_d;
  logic [CW-1:0]    rem_q, rem_d;

  logic [32:0]      w_req;
  logic [CW-1:0]    w_clamped;
  logic             w_xfer;
  logic             w_last;
  logic [AW-1:0]    w_c;

  assign w_req     = {1'b0, num_samples};
  assign w_clamped = (w_req > c_MAX_SAMPLES) ? c_MAX_SAMPLES[CW-1:0] : w_req[CW-1:0];
  assign w_xfer    = (state_q == c_RUN) && ready_in;
  assign w_last    = (rem_q == CW'(1));

  // Position of the lowest zero bit of n. Only consulted on non-final
  // transfers, where the clamp keeps n below 2^QFRAC-1, so a zero exists.
  always_comb begin
    w_c = '0;
    for (int i = QFRAC - 1; i >= 0; i--) begin
      if (!n_q[i]) w_c = AW'(i);
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= c_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: if (start) state_d = (w_clamped != '0) ? c_RUN : c_DONE;
      c_RUN:  if (w_xfer && w_last) state_d = c_DONE;
      c_DONE: state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    valid_out = (state_q == c_RUN);
    busy      = (state_q == c_RUN);
    done      = (state_q == c_DONE);
    u         = {{(WIDTH-QFRAC){1'b0}}, x_q};
  end

  // --------------------------------------------------------------------------
  // Datapath: Gray-code-order Sobol recurrence
  // --------------------------------------------------------------------------
  always_comb begin
    x_d   = x_q;
    n_d   = n_q;
    rem_d = rem_q;
    if ((state_q == c_IDLE) && start) begin
      x_d   = (SKIP_ZERO != 0) ? dir_q[0] : '0;
      n_d   = c_N_START;
      rem_d = w_clamped;
    end else if (w_xfer && !w_last) begin
      // The final transfer leaves x/n alone: its lowest-zero index would
      // fall off the table and the value is never observed.
      x_d   = x_q ^ dir_q[w_c];
      n_d   = n_q + QFRAC'(1);
      rem_d = rem_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q   <= '0;
      n_q   <= '0;
      rem_q <= '0;
    end else begin
      x_q   <= x_d;
      n_q   <= n_d;
      rem_q <= rem_d;
    end
  end

  // Direction table: van der Corput on reset, writable only while IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < QFRAC; k++) begin
        dir_q[k] <= QFRAC'(1) << (QFRAC - 1 - k);
      end
    end else if (dir_we && (state_q == c_IDLE) && (int'(dir_addr) < QFRAC)) begin
      dir_q[dir_addr] <= dir_data;
    end
  end

endmodule
`default_nettype wire

// File: doc/sobol_u_gen.md
SOBOL_U_GEN -- requirements
Module: sobol_u_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the total width of the output sample u.
REQ-002 The block SHALL have parameter QFRAC, default 16, giving the number of fractional bits of u and the Sobol resolution.
REQ-003 The block SHALL have parameter SKIP_ZERO, default 1; when 1, the sequence starts at index 1 so that u=0 is never emitted.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-005 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: single-cycle request to begin a run.
REQ-007 The block SHALL have port num_samples, input, 32 bits: number of samples to emit, sampled when start is accepted.
REQ-008 The block SHALL have port dir_we, input, 1 bit: write enable for the direction-number table.
REQ-009 The block SHALL have port dir_addr, input, $clog2(QFRAC) bits: direction-number index k.
REQ-010 The block SHALL have port dir_data, input, QFRAC bits: direction number v_k.
REQ-011 The block SHALL have port ready_in, input, 1 bit: downstream (inverseCDF_step1) is ready to accept.
REQ-012 The block SHALL have port valid_out, output, 1 bit: u holds a valid sample.
REQ-013 The block SHALL have port u, output, WIDTH bits, signed: sample in [0,1) in Q(WIDTH-QFRAC).QFRAC format.
REQ-014 The block SHALL have port busy, output, 1 bit: high while in state RUN.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle pulse when a run completes.

Function
REQ-016 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-017 IDLE -> RUN SHALL occur on start=1 with clamped num_samples > 0; IDLE -> DONE SHALL occur on start=1 with num_samples = 0; DONE -> IDLE SHALL occur after exactly one cycle.
REQ-018 start SHALL be ignored while the FSM is in RUN or DONE.
REQ-019 num_samples SHALL be clamped to 2^QFRAC - SKIP_ZERO.
REQ-020 The table holds QFRAC entries of width QFRAC; dir_we SHALL write dir_data to entry dir_addr only in IDLE, and writes in any other state SHALL be dropped.
REQ-021 On entering RUN, the state x SHALL be set to v_0 if SKIP_ZERO=1, or to 0 if SKIP_ZERO=0; the index n SHALL be set to SKIP_ZERO.
REQ-022 valid_out SHALL be high in every RUN cycle, starting in the first RUN cycle (one cycle after start), and SHALL be low in IDLE and DONE.
REQ-023 u SHALL equal x zero-extended to WIDTH bits, with integer bits = 0 and u[QFRAC-1:0] = x.
REQ-024 A transfer occurs when valid_out && ready_in; on a transfer, x SHALL become x XOR v_c, where c = position of the lowest zero bit of n, and n SHALL increment by 1.
REQ-025 While valid_out && !ready_in, u, x and n SHALL hold stable.
REQ-026 A transfer of the last sample SHALL move RUN -> DONE; valid_out SHALL drop in the following cycle, and done SHALL be high for exactly that one DONE cycle.
REQ-027 Because of the clamp, c SHALL always be < QFRAC, so no out-of-range table access is possible.
REQ-028 Throughput SHALL be one sample per cycle while ready_in=1.

Reset
REQ-029 When rst_n=0 at a clock edge, the FSM SHALL go to IDLE; valid_out, busy and done SHALL be 0; u, x and n SHALL be 0; and table entry k SHALL be set to 1<<(QFRAC-1-k) (van der Corput).
REQ-030 Reset SHALL take effect mid-run, with no further samples emitted and no done pulse.

Verification
REQ-031 Default table, SKIP_ZERO=1, ready_in=1, start with num_samples=4 -> u = 0x8000, 0xC000, 0x4000, 0x6000 on consecutive cycles, then done pulses once.
REQ-032 Same run as REQ-031 with ready_in held low for 3 cycles at sample 2 -> u holds 0xC000 and valid_out stays high through the stall; the total sequence is unchanged.
REQ-033 start with num_samples=0 -> no valid_out, and done pulses one cycle after start.
REQ-034 Write v_0=0x4000 in IDLE, then run 2 samples -> u = 0x4000, 0x0000; a dir_we issued during RUN does not change the output.
REQ-035 rst_n=0 asserted after 2 of 10 samples -> the next cycle shows valid_out=0, busy=0, u=0; a new run restarts at 0x8000.
REQ-036 num_samples=0xFFFFFFFF with QFRAC=16 -> exactly 65535 samples; the last sample carries no out-of-range index; done pulses once.
